fsm_monitor: RTL

Passive checker that sits beside the go/jump state machine and consumes the same `go`/`jump` stimulus that drives it. It runs its own reference copy of the five-state transition function, predicts `y` every cycle, and compares the prediction against the DUT's actual `y`. It is used in benches and as an optional synthesizable on-chip checker. It flags and counts divergences and records when the first one occurred.

---
 rtl/fsm_pkg.sv | 46 ++++
 rtl/fsm_ref_model.sv | 40 ++++
 rtl/fsm_monitor.sv | 110 +++++++++++
 3 files changed

// File: rtl/fsm_pkg.sv
// ============================================================================
// Module   : fsm_pkg
// Purpose  : Shared state encoding, next-state and output decode for the
//            go/jump FSM and its reference model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package fsm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_e;

    function automatic logic exp_y_of(input state_e s);
        return (s == S3) || (s == S4);
    endfunction

    function automatic state_e next_state(input state_e s, input logic go, input logic jump);
        state_e n;
        n = S0;
        case (s)
            S0: begin
                if (go && jump) n = S3;
                else if (go)    n = S1;
                else            n = S0;
            end
            S1:      n = jump ? S3 : S2;
            S2:      n = S3;
            S3:      n = jump ? S3 : S4;
            S4:      n = go ? S1 : S0;
            default: n = S0;
        endcase
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fsm_ref_model.sv
// ============================================================================
// Module   : fsm_ref_model
// Purpose  : Reference copy of the go/jump FSM: state register plus exp_y.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fsm_ref_model
    import fsm_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic                jump,
    output logic [STATE_W-1:0]  state,
    output logic                exp_y
);

    state_e state_q;
    state_e state_d;

    always_comb begin
        state_d = next_state(state_q, go, jump);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;
    assign exp_y = exp_y_of(state_q);

endmodule

`default_nettype wire

// File: rtl/fsm_monitor.sv
// ============================================================================
// Module   : fsm_monitor
// Purpose  : Passive checker comparing the monitored FSM's y against a
//            reference model; flags, counts and timestamps divergences.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fsm_monitor
    import fsm_pkg::*;
#(
    parameter int COUNT_W = 8
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                go,
    input  logic                jump,
    input  logic                y,
    output logic [STATE_W-1:0]  exp_state,
    output logic                exp_y,
    output logic                mismatch,
    output logic [COUNT_W-1:0]  err_count,
    output logic [COUNT_W-1:0]  cycle_count,
    output logic [COUNT_W-1:0]  first_err_cycle
);

    localparam logic [COUNT_W-1:0] c_CNT_MAX = '1;

    logic               armed_q;
    logic               armed_d;
    logic               mismatch_q;
    logic               mismatch_d;
    logic [COUNT_W-1:0] err_count_q;
    logic [COUNT_W-1:0] err_count_d;
    logic [COUNT_W-1:0] cycle_count_q;
    logic [COUNT_W-1:0] cycle_count_d;
    logic [COUNT_W-1:0] first_err_q;
    logic [COUNT_W-1:0] first_err_d;

    logic               w_diff;
    logic               w_fail;

    fsm_ref_model u_ref (
        .clk   (clk),
        .reset (reset),
        .go    (go),
        .jump  (jump),
        .state (exp_state),
        .exp_y (exp_y)
    );

    // Case inequality in simulation so an unknown y is reported as a failure.
`ifdef SYNTHESIS
    assign w_diff = (y != exp_y);
`else
    assign w_diff = (y !== exp_y);
`endif

    // Unarmed first edge after reset release is never compared.
    assign w_fail = armed_q & en & w_diff;

    always_comb begin
        armed_d       = 1'b1;
        mismatch_d    = mismatch_q;
        err_count_d   = err_count_q;
        cycle_count_d = cycle_count_q;
        first_err_d   = first_err_q;

        if (armed_q && (cycle_count_q != c_CNT_MAX)) begin
            cycle_count_d = cycle_count_q + 1'b1;
        end

        if (w_fail) begin
            if (err_count_q != c_CNT_MAX) begin
                err_count_d = err_count_q + 1'b1;
            end
            if (!mismatch_q) begin
                mismatch_d  = 1'b1;
                first_err_d = cycle_count_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed_q       <= 1'b0;
            mismatch_q    <= 1'b0;
            err_count_q   <= '0;
            cycle_count_q <= '0;
            first_err_q   <= '0;
        end else begin
            armed_q       <= armed_d;
            mismatch_q    <= mismatch_d;
            err_count_q   <= err_count_d;
            cycle_count_q <= cycle_count_d;
            first_err_q   <= first_err_d;
        end
    end

    assign mismatch        = mismatch_q;
    assign err_count       = err_count_q;
    assign cycle_count     = cycle_count_q;
    assign first_err_cycle = first_err_q;

endmodule

`default_nettype wire
